restoring_divider: RTL and testbench

RESTORING_DIVIDER -- requirements
Module: restoring_divider

---
 rtl/restoring_divider_pkg.sv | 12 +
 rtl/Full_Subtractor.sv | 24 ++
 rtl/restoring_divider.sv | 125 ++++++++++++
 tb/tb_restoring_divider.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/restoring_divider_pkg.sv
// rtl/restoring_divider_pkg.sv - shared width default and FSM encodings for the restoring divider
package restoring_divider_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIN  = 2'b10
   } state_e;

endpackage

// File: rtl/Full_Subtractor.sv
// rtl/Full_Subtractor.sv - gate-level one-bit full subtractor (A - B - BIN)
module Full_Subtractor (
   input  wire A,
   input  wire B,
   input  wire BIN,
   output wire D,
   output wire BOUT
);

   wire a_xor_b;
   wire a_n;
   wire a_xnor_b;
   wire brw_ab;
   wire brw_in;

   xor g_x0 (a_xor_b, A, B);
   xor g_x1 (D, a_xor_b, BIN);
   not g_n0 (a_n, A);
   and g_a0 (brw_ab, a_n, B);
   not g_n1 (a_xnor_b, a_xor_b);
   and g_a1 (brw_in, a_xnor_b, BIN);
   or  g_o0 (BOUT, brw_ab, brw_in);

endmodule

// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - multi-cycle unsigned restoring divider, one quotient bit per cycle
module restoring_divider
   import restoring_divider_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] DIVIDEND,
   input  logic [WIDTH-1:0] DIVISOR,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] QUOTIENT,
   output logic [WIDTH-1:0] REMAINDER,
   output logic             DIV_BY_ZERO
);

   localparam int CW = $clog2(WIDTH + 1);

   state_e           state_q;
   logic [WIDTH-1:0] dvd_q;
   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH-1:0] rem_q;
   logic [CW-1:0]    cnt_q;
   logic             busy_q;
   logic             done_q;
   logic             dbz_q;
   logic [WIDTH-1:0] quo_out_q;
   logic [WIDTH-1:0] rem_out_q;

   logic [WIDTH:0]   trial_a;
   logic [WIDTH:0]   trial_b;
   logic [WIDTH:0]   diff;
   logic [WIDTH+1:0] borrow;
   logic             keep;
   logic [WIDTH-1:0] rem_d;
   logic [WIDTH-1:0] quo_d;
   logic             unused_diff_msb;

   // dvd_q shifts dividend bits out of the top while quotient bits enter at the bottom
   assign trial_a   = {rem_q, dvd_q[WIDTH-1]};
   assign trial_b   = {1'b0, dvs_q};
   assign borrow[0] = 1'b0;

   for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
      Full_Subtractor u_fs (
         .A    (trial_a[i]),
         .B    (trial_b[i]),
         .BIN  (borrow[i]),
         .D    (diff[i]),
         .BOUT (borrow[i+1])
      );
   end

   // A non-negative difference is below the divisor, so its top bit is always zero
   assign keep            = ~borrow[WIDTH+1];
   assign rem_d           = keep ? diff[WIDTH-1:0] : trial_a[WIDTH-1:0];
   assign quo_d           = {dvd_q[WIDTH-2:0], keep};
   assign unused_diff_msb = diff[WIDTH];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= IDLE;
         dvd_q     <= '0;
         dvs_q     <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
         quo_out_q <= '0;
         rem_out_q <= '0;
      end else begin
         case (state_q)
            IDLE, FIN: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state_q <= IDLE;
               if (START) begin
                  dvd_q <= DIVIDEND;
                  dvs_q <= DIVISOR;
                  rem_q <= '0;
                  cnt_q <= CW'(WIDTH);
                  if (DIVISOR == '0) begin
                     state_q   <= FIN;
                     done_q    <= 1'b1;
                     dbz_q     <= 1'b1;
                     quo_out_q <= '1;
                     rem_out_q <= DIVIDEND;
                  end else begin
                     state_q <= CALC;
                     busy_q  <= 1'b1;
                     dbz_q   <= 1'b0;
                  end
               end
            end
            CALC: begin
               rem_q <= rem_d;
               dvd_q <= quo_d;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_q   <= FIN;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  quo_out_q <= quo_d;
                  rem_out_q <= rem_d;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign BUSY        = busy_q;
   assign DONE        = done_q;
   assign QUOTIENT    = quo_out_q;
   assign REMAINDER   = rem_out_q;
   assign DIV_BY_ZERO = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// tb/tb_restoring_divider.sv - directed and random checks of restoring_divider at WIDTH=8
module tb_restoring_divider;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       dbz;

   int n_total = 0;
   int n_pass  = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] q;
      logic [7:0] r;
      logic       z;
   } vec_t;

   vec_t vecs[11];

   restoring_divider #(.WIDTH(8)) dut (
      .CLK         (clk),
      .RST         (rst),
      .START       (start),
      .DIVIDEND    (dividend),
      .DIVISOR     (divisor),
      .BUSY        (busy),
      .DONE        (done),
      .QUOTIENT    (quotient),
      .REMAINDER   (remainder),
      .DIV_BY_ZERO (dbz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic wait_done(output int lat, output int bc);
      lat = 1;
      bc  = 0;
      while (!done && lat < 40) begin
         if (busy) bc++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int lat;
      int bc;
      start    = 1'b1;
      dividend = v.a;
      divisor  = v.b;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, bc);
      check({tag, "_latency"}, lat, (v.b == 0) ? 1 : 9);
      check({tag, "_busy_cycles"}, bc, (v.b == 0) ? 0 : 8);
      check({tag, "_quotient"}, quotient, v.q);
      check({tag, "_remainder"}, remainder, v.r);
      check({tag, "_div_by_zero"}, dbz, v.z);
      @(negedge clk);
      check({tag, "_done_pulse_width"}, done, 0);
   endtask

   initial begin
      int lat;
      int bc;
      int seen;
      int a;
      int b;

      vecs[0]  = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0};
      vecs[1]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
      vecs[2]  = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
      vecs[3]  = '{8'd200, 8'd13,  8'd15,  8'd5,   1'b0};
      vecs[4]  = '{8'd9,   8'd3,   8'd3,   8'd0,   1'b0};
      vecs[5]  = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
      vecs[6]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
      vecs[7]  = '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0};
      vecs[8]  = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0};
      vecs[9]  = '{8'd17,  8'd16,  8'd1,   8'd1,   1'b0};
      vecs[10] = '{8'd77,  8'd0,   8'd255, 8'd77,  1'b1};

      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      @(negedge clk);
      @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_quotient", quotient, 0);
      check("reset_remainder", remainder, 0);
      check("reset_div_by_zero", dbz, 0);

      // start accepted on the very first edge after reset release
      rst = 1'b0;
      for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // reset while idle clears the sticky div-by-zero flag and results
      rst = 1'b1;
      #1;
      check("idle_reset_div_by_zero", dbz, 0);
      check("idle_reset_quotient", quotient, 0);
      check("idle_reset_remainder", remainder, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // START pulsed mid-CALC must not disturb the running division
      start = 1'b1; dividend = 8'd100; divisor = 8'd7;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; dividend = 8'd50; divisor = 8'd3;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, bc);
      check("ignore_latency", lat, 7);
      check("ignore_quotient", quotient, 14);
      check("ignore_remainder", remainder, 2);
      @(negedge clk);
      check("ignore_done_pulse_width", done, 0);

      // back-to-back: START held during FIN launches the next division
      start = 1'b1; dividend = 8'd100; divisor = 8'd7;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, bc);
      check("b2b_first_quotient", quotient, 14);
      check("b2b_first_remainder", remainder, 2);
      start = 1'b1; dividend = 8'd200; divisor = 8'd13;
      @(negedge clk);
      start = 1'b0;
      check("b2b_busy_after_fin", busy, 1);
      check("b2b_quotient_held", quotient, 14);
      wait_done(lat, bc);
      check("b2b_latency", lat, 9);
      check("b2b_busy_cycles", bc, 8);
      check("b2b_quotient", quotient, 15);
      check("b2b_remainder", remainder, 5);
      @(negedge clk);

      // reset in the 4th CALC cycle abandons the division
      start = 1'b1; dividend = 8'd100; divisor = 8'd7;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midreset_busy", busy, 0);
      check("midreset_done", done, 0);
      check("midreset_quotient", quotient, 0);
      check("midreset_remainder", remainder, 0);
      check("midreset_div_by_zero", dbz, 0);
      @(negedge clk);
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      check("midreset_no_done", seen, 0);
      run_vec('{8'd9, 8'd3, 8'd3, 8'd0, 1'b0}, "post_reset");

      // random operands against a reference model and the division invariant
      for (int i = 0; i < 1000; i++) begin
         a = int'($urandom_range(0, 255));
         b = int'($urandom_range(1, 255));
         start = 1'b1; dividend = 8'(a); divisor = 8'(b);
         @(negedge clk);
         start = 1'b0;
         wait_done(lat, bc);
         n_total++;
         if (lat == 9 && quotient == 8'(a / b) && remainder == 8'(a % b)) n_pass++;
         else $display("FAIL rand_model %0d/%0d: got q=%0d r=%0d lat=%0d expected q=%0d r=%0d lat=9",
                       a, b, quotient, remainder, lat, a / b, a % b);
         n_total++;
         if (int'(quotient) * b + int'(remainder) == a && int'(remainder) < b) n_pass++;
         else $display("FAIL rand_invariant %0d/%0d: got q=%0d r=%0d", a, b, quotient, remainder);
         @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
